coincidence_output_arbiter: RTL

- Merges the event outputs of NUM_CH parallel coincidence units (one per detector-pair channel) into a single registered output stream for the packet/transfer stage.
- Each channel has a one-entry holding register; a round-robin scheduler grants the output to pending channels under a valid/ready handshake.
- Keeps saturating statistics (events forwarded, events dropped) and per-channel sticky overflow flags for the control interface.

---
 rtl/coincidence_output_arbiter.sv | 82 ++++++++
 1 files changed

// File: rtl/coincidence_output_arbiter.sv
// coincidence_output_arbiter: round-robin merge of per-channel coincidence records
// into one registered valid/ready stream, with saturating stats and overflow flags.
module coincidence_output_arbiter #(
   parameter int NUM_CH      = 4,
   parameter int CH_ID_WIDTH = 2,
   parameter int DATA_WIDTH  = 256
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         enable,
   input  logic                         clr_stats,
   input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data,
   input  logic [NUM_CH-1:0]            ch_en,
   output logic [DATA_WIDTH-1:0]        odata,
   output logic [CH_ID_WIDTH-1:0]       odata_ch,
   output logic                         odata_valid,
   input  logic                         odata_ready,
   output logic [NUM_CH-1:0]            overflow_flags,
   output logic [31:0]                  event_count,
   output logic [15:0]                  drop_count
);
   typedef enum logic {S_IDLE, S_OUT} state_t;
   state_t state, state_n;
   logic [NUM_CH-1:0] pending, cap, drop;
   logic [DATA_WIDTH-1:0] hold [NUM_CH];
   logic [CH_ID_WIDTH-1:0] ptr, win;
   logic found, grant, xfer;
   logic [4:0] ndrop;
   logic [16:0] dsum;
   // lowest pending channel overall, then overridden by the lowest one at or above ptr
   always_comb begin
      win = '0;
      found = 1'b0;
      for (int k = NUM_CH - 1; k >= 0; k--)
         if (pending[k]) begin
            win = CH_ID_WIDTH'(k);
            found = 1'b1;
         end
      for (int k = NUM_CH - 1; k >= 0; k--)
         if (pending[k] && CH_ID_WIDTH'(k) >= ptr) win = CH_ID_WIDTH'(k);
   end
   always_comb begin
      grant = found && (state == S_IDLE || odata_ready);
      xfer = state == S_OUT && odata_ready;
      state_n = grant ? S_OUT : xfer ? S_IDLE : state;
      for (int k = 0; k < NUM_CH; k++) begin
         cap[k] = enable && ch_en[k] && (!pending[k] || (grant && win == CH_ID_WIDTH'(k)));
         drop[k] = enable && ch_en[k] && !cap[k];
      end
      ndrop = 5'($countones(drop));
      dsum = {1'b0, drop_count} + 17'(ndrop);
   end
   assign odata_valid = state == S_OUT;
   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= S_IDLE;
      else state <= state_n;
   always_ff @(posedge clk)
      for (int k = 0; k < NUM_CH; k++)
         if (cap[k]) hold[k] <= ch_data[k*DATA_WIDTH +: DATA_WIDTH];
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         pending <= '0;
         ptr <= '0;
         odata <= '0;
         odata_ch <= '0;
         overflow_flags <= '0;
         event_count <= '0;
         drop_count <= '0;
      end else begin
         if (grant) begin
            odata <= hold[win];
            odata_ch <= win;
            ptr <= CH_ID_WIDTH'((int'(win) + 1) % NUM_CH);
         end
         for (int k = 0; k < NUM_CH; k++)
            if (cap[k]) pending[k] <= 1'b1;
            else if (grant && win == CH_ID_WIDTH'(k)) pending[k] <= 1'b0;
         event_count <= clr_stats ? '0 : (xfer && event_count != '1) ? event_count + 32'd1 : event_count;
         drop_count <= clr_stats ? '0 : dsum[16] ? 16'hFFFF : dsum[15:0];
         overflow_flags <= clr_stats ? '0 : overflow_flags | drop;
      end
endmodule
